// File: rtl/mem_access_stage.sv
// Memory access stage: registers the execute result, runs loads/stores
// against a handshaked data memory and emits one writeback packet per
// accepted instruction. Upstream is stalled while an access is in flight.
module mem_access_stage #(
    parameter int TIMEOUT  = 16,
    parameter int RESULT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [RESULT_W-1:0] alu_result,
    input  logic [RESULT_W-1:0] store_data,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [1:0]          mem_size,
    input  logic                mem_unsigned,
    input  logic                reg_write,
    input  logic [4:0]          write_reg,
    output logic                stall,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [RESULT_W-1:0] dmem_addr,
    output logic [3:0]          dmem_be,
    output logic [RESULT_W-1:0] dmem_wdata,
    input  logic                dmem_ready,
    input  logic [RESULT_W-1:0] dmem_rdata,
    output logic                wb_valid,
    output logic [RESULT_W-1:0] wb_data,
    output logic [4:0]          wb_reg,
    output logic                wb_regwrite,
    output logic                misalign,
    output logic                bus_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // A zero TIMEOUT disables the watchdog entirely.
    localparam bit          TO_EN      = (TIMEOUT > 0);
    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

    state_t        state_reg, state_next;
    logic [31:0]   timer_reg;
    logic [1:0]    addr_lo_reg;
    logic [1:0]    size_reg;
    logic          unsigned_reg;
    logic          is_load_reg;
    logic          regwrite_reg;

    logic          is_mem;
    logic          misaligned_in;
    logic          timed_out;
    logic [3:0]    be_in;
    logic [31:0]   wdata_in;
    logic [7:0]    rd_bytes [4];
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_ext;

    assign stall         = (state_reg != IDLE);
    assign is_mem        = mem_read | mem_write;
    assign misaligned_in = ((mem_size == 2'b01) && alu_result[0]) ||
                           (mem_size[1] && (alu_result[1:0] != 2'b00));
    // Counter value TIMEOUT-1 marks the last ACCESS cycle the bus is granted.
    assign timed_out     = TO_EN && (timer_reg == TIMEOUT_M1);

    // Per-lane byte enables and read-data lane split.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign rd_bytes[gi] = dmem_rdata[8*gi +: 8];
            assign be_in[gi]    = mem_size[1] ||
                                  ((mem_size == 2'b01) && (alu_result[1] == LANE[1])) ||
                                  ((mem_size == 2'b00) && (alu_result[1:0] == LANE));
        end
    endgenerate

    // Store data replicated across the lanes the access can hit.
    always_comb begin
        wdata_in = store_data;
        case (mem_size)
            2'b00:   wdata_in = {4{store_data[7:0]}};
            2'b01:   wdata_in = {2{store_data[15:0]}};
            default: wdata_in = store_data;
        endcase
    end

    // Load lane selection and sign/zero extension of the returned word.
    always_comb begin
        sel_byte = rd_bytes[addr_lo_reg];
        sel_half = addr_lo_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_ext = dmem_rdata;
        case (size_reg)
            2'b00:   load_ext = {{24{~unsigned_reg & sel_byte[7]}}, sel_byte};
            2'b01:   load_ext = {{16{~unsigned_reg & sel_half[15]}}, sel_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid && is_mem && !misaligned_in) state_next = ACCESS;
            ACCESS:  if (dmem_ready || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Datapath: capture, memory bus registers, writeback packet and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg    <= '0;
            addr_lo_reg  <= '0;
            size_reg     <= '0;
            unsigned_reg <= 1'b0;
            is_load_reg  <= 1'b0;
            regwrite_reg <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_reg       <= '0;
            wb_regwrite  <= 1'b0;
            misalign     <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        wb_reg <= write_reg;
                        if (!is_mem) begin
                            wb_valid    <= 1'b1;
                            wb_data     <= alu_result;
                            wb_regwrite <= reg_write;
                        end else if (misaligned_in) begin
                            wb_valid <= 1'b1;
                            misalign <= 1'b1;
                            wb_data  <= alu_result;
                        end else begin
                            dmem_req     <= 1'b1;
                            dmem_we      <= mem_write;
                            dmem_addr    <= {alu_result[31:2], 2'b00};
                            dmem_be      <= be_in;
                            dmem_wdata   <= wdata_in;
                            addr_lo_reg  <= alu_result[1:0];
                            size_reg     <= mem_size;
                            unsigned_reg <= mem_unsigned;
                            is_load_reg  <= ~mem_write;
                            regwrite_reg <= reg_write;
                            timer_reg    <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ready) begin
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_regwrite <= is_load_reg & regwrite_reg;
                        if (is_load_reg) wb_data <= load_ext;
                    end else if (timed_out) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        wb_valid <= 1'b1;
                        bus_err  <= 1'b1;
                        wb_data  <= '0;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a spec-level model predicts every
// transaction's bus request and writeback; a negedge process compares.
module tb_mem_access_stage;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] alu_result, store_data;
    logic        mem_read, mem_write, mem_unsigned, reg_write;
    logic [1:0]  mem_size;
    logic [4:0]  write_reg;
    logic        stall, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_regwrite, misalign, bus_err;
    logic [4:0]  wb_reg;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO), .RESULT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .reg_write(reg_write),
        .write_reg(write_reg), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_data(wb_data), .wb_reg(wb_reg), .wb_regwrite(wb_regwrite),
        .misalign(misalign), .bus_err(bus_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected outputs for the current cycle.
    bit          chk_en;
    logic        e_stall, e_req, e_we, e_wbv, e_mis, e_berr, e_rw;
    logic [31:0] e_addr, e_wdata, e_wbdata;
    logic [3:0]  e_be;
    logic [4:0]  e_reg;
    bit          e_chk_data;
    int          stall_cnt, req_cnt;
    logic [3:0]  last_be;
    logic [31:0] last_wdata, last_wbdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec-level model of one memory access.
    function automatic void model(input logic [31:0] addr, sd, rdata, input logic [1:0] size,
                                  input bit uns, output bit mis, output logic [3:0] be,
                                  output logic [31:0] wdata, output logic [31:0] ld);
        int nb;
        int off;
        logic [31:0] mask, val;
        nb    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off   = int'(addr % 4);
        mis   = (addr % nb) != 0;
        be    = 4'(((1 << nb) - 1) << off);
        wdata = (nb == 1) ? sd[7:0] * 32'h01010101 :
                (nb == 2) ? sd[15:0] * 32'h00010001 : sd;
        mask  = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
        val   = (rdata >> (8 * off)) & mask;
        if (!uns && val[8*nb-1]) val = val | ~mask;
        ld = val;
    endfunction

    // Per-cycle compare against the expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(e_stall));
            check("dmem_req", 32'(dmem_req), 32'(e_req));
            check("wb_valid", 32'(wb_valid), 32'(e_wbv));
            check("misalign", 32'(misalign), 32'(e_mis));
            check("bus_err", 32'(bus_err), 32'(e_berr));
            if (stall) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                last_be    = dmem_be;
                last_wdata = dmem_wdata;
            end
            if (e_req) begin
                check("dmem_addr", dmem_addr, e_addr);
                check("dmem_be", 32'(dmem_be), 32'(e_be));
                check("dmem_we", 32'(dmem_we), 32'(e_we));
                if (e_we) check("dmem_wdata", dmem_wdata, e_wdata);
            end
            if (e_wbv) begin
                last_wbdata = wb_data;
                if (e_chk_data) check("wb_data", wb_data, e_wbdata);
                check("wb_reg", 32'(wb_reg), 32'(e_reg));
                check("wb_regwrite", 32'(wb_regwrite), 32'(e_rw));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        e_stall = 0; e_req = 0; e_wbv = 0; e_mis = 0; e_berr = 0;
    endtask

    task automatic idle();
        step();
        set_idle_exp();
    endtask

    task automatic drive(input logic [31:0] a, sd, input bit rd, wr, input logic [1:0] sz,
                         input bit uns, rw, input logic [4:0] rg);
        in_valid = 1; alu_result = a; store_data = sd; mem_read = rd; mem_write = wr;
        mem_size = sz; mem_unsigned = uns; reg_write = rw; write_reg = rg;
    endtask

    task automatic alu_op(input logic [31:0] a, input logic [4:0] rg, input bit rw);
        drive(a, 32'h0, 0, 0, 2'b10, 0, rw, rg);
        step();
        in_valid = 0;
        set_idle_exp();
        e_wbv = 1; e_chk_data = 1; e_wbdata = a; e_reg = rg; e_rw = rw;
    endtask

    task automatic mem_op(input logic [31:0] a, sd, input bit rd, wr, input logic [1:0] sz,
                          input bit uns, rw, input logic [4:0] rg, input int waits,
                          input bit never, input logic [31:0] rdata);
        bit mis;
        logic [3:0] be;
        logic [31:0] wd, ld;
        int n;
        model(a, sd, rdata, sz, uns, mis, be, wd, ld);
        stall_cnt = 0; req_cnt = 0;
        drive(a, sd, rd, wr, sz, uns, rw, rg);
        step();
        if (mis) begin
            in_valid = 0;
            set_idle_exp();
            e_wbv = 1; e_mis = 1; e_rw = 0; e_reg = rg; e_chk_data = 0;
            idle();
            return;
        end
        e_stall = 1; e_req = 1; e_addr = {a[31:2], 2'b00}; e_be = be; e_we = wr; e_wdata = wd;
        n = never ? TO : waits + 1;
        for (int i = 0; i < n; i++) begin
            dmem_ready = !never && (i == waits);
            dmem_rdata = rdata;
            step();
        end
        dmem_ready = 0;
        e_req = 0; e_wbv = 1; e_berr = never; e_reg = rg;
        e_rw = never ? 1'b0 : (rd & ~wr & rw);
        e_chk_data = never || !wr;
        e_wbdata = never ? 32'h0 : ld;
        step();
        in_valid = 0;
        set_idle_exp();
    endtask

    initial begin
        rst_n = 0; in_valid = 0; alu_result = 0; store_data = 0; mem_read = 0; mem_write = 0;
        mem_size = 0; mem_unsigned = 0; reg_write = 0; write_reg = 0;
        dmem_ready = 0; dmem_rdata = 0; chk_en = 0; e_chk_data = 0;
        e_we = 0; e_rw = 0; e_addr = 0; e_wdata = 0; e_wbdata = 0; e_be = 0; e_reg = 0;
        stall_cnt = 0; req_cnt = 0; last_be = 0; last_wdata = 0; last_wbdata = 0;
        set_idle_exp();
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", 32'(stall), 0);
        check("reset_req", 32'(dmem_req), 0);
        check("reset_wb_valid", 32'(wb_valid), 0);
        check("reset_wb_data", wb_data, 0);
        check("reset_bus_err", 32'(bus_err), 0);
        rst_n = 1;
        chk_en = 1;
        idle();

        // ALU ops back-to-back
        stall_cnt = 0;
        alu_op(32'h1234_5678, 5'd5, 1);
        alu_op(32'h0, 5'd6, 1);
        idle();
        check("alu_stall_cycles", stall_cnt, 0);

        // lb / lbu at 0x103, two wait cycles
        mem_op(32'h103, 32'h0, 1, 0, 2'b00, 0, 1, 5'd7, 2, 0, 32'h80FF_0000);
        check("lb_stall_cycles", stall_cnt, 4);
        check("lb_be", 32'(last_be), 32'h8);
        check("lb_data", last_wbdata, 32'hFFFF_FF80);
        idle();
        mem_op(32'h103, 32'h0, 1, 0, 2'b00, 1, 1, 5'd7, 2, 0, 32'h80FF_0000);
        check("lbu_data", last_wbdata, 32'h0000_0080);
        idle();

        // sh at 0x202, ready immediate
        mem_op(32'h202, 32'hAAAA_BEEF, 0, 1, 2'b01, 0, 1, 5'd8, 0, 0, 32'h0);
        check("sh_be", 32'(last_be), 32'hC);
        check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        idle();

        // lh signed high half, lw aligned, sw with mem_read also set
        mem_op(32'h12, 32'h0, 1, 0, 2'b01, 0, 1, 5'd9, 1, 0, 32'h8001_1234);
        check("lh_data", last_wbdata, 32'hFFFF_8001);
        mem_op(32'h10, 32'h0, 1, 0, 2'b10, 0, 1, 5'd10, 0, 0, 32'h7654_3210);
        mem_op(32'h400, 32'h1122_3344, 1, 1, 2'b10, 0, 1, 5'd11, 1, 0, 32'hFFFF_FFFF);
        check("sw_wdata", last_wdata, 32'h1122_3344);
        idle();

        // misaligned lw
        mem_op(32'h6, 32'h0, 1, 0, 2'b10, 0, 1, 5'd12, 0, 0, 32'h0);
        check("misalign_req_cycles", req_cnt, 0);

        // dmem_ready while idle is ignored
        dmem_ready = 1;
        idle();
        idle();
        dmem_ready = 0;

        // timeout, then ready on the last allowed cycle
        mem_op(32'h300, 32'h0, 1, 0, 2'b10, 0, 1, 5'd13, 0, 1, 32'h0);
        check("timeout_req_cycles", req_cnt, TO);
        idle();
        mem_op(32'h300, 32'h0, 1, 0, 2'b10, 0, 1, 5'd14, TO - 1, 0, 32'hCAFE_F00D);
        check("late_ready_req_cycles", req_cnt, TO);
        check("late_ready_data", last_wbdata, 32'hCAFE_F00D);
        idle();

        // reset mid-ACCESS
        drive(32'h40, 32'h0, 1, 0, 2'b10, 0, 1, 5'd15);
        step();
        e_stall = 1; e_req = 1; e_addr = 32'h40; e_be = 4'hF; e_we = 0;
        step();
        step();
        chk_en = 0;
        #2 rst_n = 0;
        #1;
        check("rst_async_req", 32'(dmem_req), 0);
        check("rst_async_stall", 32'(stall), 0);
        check("rst_async_wb_valid", 32'(wb_valid), 0);
        step();
        in_valid = 0;
        rst_n = 1;
        set_idle_exp();
        chk_en = 1;
        repeat (4) step();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
